// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared width bounds and operation decode for the sync counters
//
// Purpose: constants and the priority-encoded per-edge operation shared by
// the synchronous up and down counter cells.
// Contents:
//   WIDTH_MIN / WIDTH_MAX  legal counter width range
//   op_e                   per-edge operation (hold, clear, load, count)
//   decode_op()            CLK-qualified priority decode: clear > load > count > hold
package counter_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_CLR  = 2'd1,
    OP_LD   = 2'd2,
    OP_CNT  = 2'd3
  } op_e;

  // Reset is not part of this decode; it is handled directly in each register.
  function automatic op_e decode_op(input logic strobe, input logic cll,
                                    input logic ld, input logic ci);
    op_e op;
    op = OP_HOLD;
    if (strobe) begin
      if (!cll)    op = OP_CLR;
      else if (ld) op = OP_LD;
      else if (ci) op = OP_CNT;
    end
    return op;
  endfunction

endpackage

// File: rtl/syn_up_counter_bit.sv
// rtl/syn_up_counter_bit.sv - single toggle cell of the synchronous up counter
//
// Purpose: one counter bit with synchronous reset, clear, load and toggle.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset (q = 0)
//   clr  in   synchronous clear (q = 0)
//   ld   in   load d
//   d    in   load value
//   tgl  in   invert q
//   q    out  bit value
module syn_up_counter_bit (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ld,
  input  logic d,
  input  logic tgl,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst)      q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (ld)  q <= d;
    else if (tgl) q <= ~q;
  end

endmodule

// File: rtl/syn_up_counter.sv
// rtl/syn_up_counter.sv - cascadable synchronous up counter with sticky TC and saturate mode
//
// Purpose: WIDTH-bit binary up counter with parallel load, clear, carry in/out
// for cascading, a sticky terminal-count flag and an optional saturate mode.
// Ports:
//   MasterClock  in   clock, all state changes on its rising edge
//   RESET        in   synchronous active-high reset
//   CLK          in   count strobe (clock enable) qualifying CLL/LD/CI
//   CLL          in   active-low clear
//   LD           in   parallel load strobe
//   D[WIDTH]     in   load value
//   CI           in   carry-in / count enable
//   SAT          in   saturate-mode value captured on load
//   TCACK        in   clears the sticky TC flag
//   Q[WIDTH]     out  counter value
//   QB[WIDTH]    out  inverse of Q
//   CO           out  carry-out: CI & (Q == all ones) & ~sat_mode
//   TC           out  sticky terminal-count flag
module syn_up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit SAT_DEFAULT = 1'b0
) (
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic             CLK,
  input  logic             CLL,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             CI,
  input  logic             SAT,
  input  logic             TCACK,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             CO,
  output logic             TC
);

  op_e              op;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] carry;
  logic             sat_mode;
  logic             tc;
  logic             all_ones;
  logic             near_ones;
  logic             inc_en;
  logic             tc_set;

  assign op        = decode_op(CLK, CLL, LD, CI);
  assign all_ones  = &q;
  assign near_ones = (&q[WIDTH-1:1]) & ~q[0];

  // In saturate mode the count stops at all ones instead of wrapping.
  assign inc_en = (op == OP_CNT) && !(sat_mode && all_ones);

  // Wrap mode flags the all-ones -> 0 transition; saturate mode flags reaching
  // (or sitting at) all ones so TC stays asserted while saturated.
  assign tc_set = (op == OP_CNT) && (sat_mode ? (all_ones || near_ones) : all_ones);

  // Ripple toggle chain: bit i toggles when all lower bits are one.
  assign carry[0] = inc_en;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry[i] = carry[i-1] & q[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    syn_up_counter_bit u_bit (
      .clk (MasterClock),
      .rst (RESET),
      .clr (op == OP_CLR),
      .ld  (op == OP_LD),
      .d   (D[i]),
      .tgl (carry[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      sat_mode <= SAT_DEFAULT;
      tc       <= 1'b0;
    end else begin
      if (op == OP_LD) sat_mode <= SAT;
      // A set on the same edge as TCACK wins; TCACK needs no CLK strobe.
      if (op == OP_CLR)  tc <= 1'b0;
      else if (tc_set)   tc <= 1'b1;
      else if (TCACK)    tc <= 1'b0;
    end
  end

  assign Q  = q;
  assign QB = ~q;
  assign CO = CI & all_ones & ~sat_mode;
  assign TC = tc;

endmodule

// File: tb/tb_syn_up_counter.sv
// tb/tb_syn_up_counter.sv - self-checking bench for syn_up_counter
module tb_syn_up_counter;

  logic       MasterClock;
  logic       RESET, CLK, CLL, LD, CI, SAT, TCACK;
  logic [7:0] D;
  logic [7:0] Q, QB;
  logic       CO, TC;

  logic       c_rst, c_clk, c_cll, c_ld, c_ci, c_sat, c_tcack;
  logic [7:0] c_d;
  logic [3:0] lo_q, hi_q, lo_qb, hi_qb;
  logic       lo_co, hi_co, lo_tc, hi_tc;

  int errors = 0;
  int checks = 0;

  int m_q;
  bit m_tc;
  bit m_sat;

  syn_up_counter #(.WIDTH(8), .SAT_DEFAULT(1'b0)) u_dut (
    .MasterClock(MasterClock), .RESET(RESET), .CLK(CLK), .CLL(CLL), .LD(LD),
    .D(D), .CI(CI), .SAT(SAT), .TCACK(TCACK),
    .Q(Q), .QB(QB), .CO(CO), .TC(TC)
  );

  syn_up_counter #(.WIDTH(4), .SAT_DEFAULT(1'b0)) u_lo (
    .MasterClock(MasterClock), .RESET(c_rst), .CLK(c_clk), .CLL(c_cll), .LD(c_ld),
    .D(c_d[3:0]), .CI(c_ci), .SAT(c_sat), .TCACK(c_tcack),
    .Q(lo_q), .QB(lo_qb), .CO(lo_co), .TC(lo_tc)
  );

  syn_up_counter #(.WIDTH(4), .SAT_DEFAULT(1'b0)) u_hi (
    .MasterClock(MasterClock), .RESET(c_rst), .CLK(c_clk), .CLL(c_cll), .LD(c_ld),
    .D(c_d[7:4]), .CI(lo_co), .SAT(c_sat), .TCACK(c_tcack),
    .Q(hi_q), .QB(hi_qb), .CO(hi_co), .TC(hi_tc)
  );

  always #5 MasterClock = ~MasterClock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: rules applied in priority order with plain integer arithmetic.
  task automatic model_edge();
    int  nq;
    bit  set_tc;
    bit  clr_tc;
    if (RESET) begin
      m_q = 0; m_tc = 0; m_sat = 0;
      return;
    end
    nq = m_q; set_tc = 0; clr_tc = 0;
    if (CLK && !CLL) begin
      nq = 0; clr_tc = 1;
    end else if (CLK && LD) begin
      nq = D; m_sat = SAT;
    end else if (CLK && CI) begin
      if (m_sat) begin
        nq = (m_q == 255) ? 255 : m_q + 1;
        set_tc = (nq == 255);
      end else begin
        nq = (m_q + 1) % 256;
        set_tc = (m_q == 255);
      end
    end
    m_q = nq;
    if (clr_tc)      m_tc = 0;
    else if (set_tc) m_tc = 1;
    else if (TCACK)  m_tc = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},  {24'd0, Q},  m_q);
    chk({tag, ".qb"}, {24'd0, QB}, 255 - m_q);
    chk({tag, ".tc"}, {31'd0, TC}, {31'd0, m_tc});
    chk({tag, ".co"}, {31'd0, CO}, {31'd0, CI && (m_q == 255) && !m_sat});
  endtask

  task automatic step(input string tag, input logic r, input logic k, input logic l,
                      input logic ld_i, input logic [7:0] d_i, input logic c,
                      input logic s, input logic a);
    RESET = r; CLK = k; CLL = l; LD = ld_i; D = d_i; CI = c; SAT = s; TCACK = a;
    @(posedge MasterClock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic cstep(input logic r, input logic k, input logic ld_i,
                       input logic [7:0] d_i, input logic c);
    c_rst = r; c_clk = k; c_cll = 1'b1; c_ld = ld_i; c_d = d_i; c_ci = c;
    c_sat = 1'b0; c_tcack = 1'b0;
    @(posedge MasterClock);
    #1;
  endtask

  initial begin
    MasterClock = 0;
    RESET = 0; CLK = 0; CLL = 1; LD = 0; D = 0; CI = 0; SAT = 0; TCACK = 0;
    c_rst = 1; c_clk = 0; c_cll = 1; c_ld = 0; c_d = 0; c_ci = 0; c_sat = 0; c_tcack = 0;
    m_q = 0; m_tc = 0; m_sat = 0;

    // Reset then count five
    step("reset", 1, 0, 1, 0, 8'h00, 0, 0, 0);
    chk("reset_q", {24'd0, Q}, 0);
    chk("reset_qb", {24'd0, QB}, 32'hFF);
    chk("reset_tc", {31'd0, TC}, 0);
    c_rst = 0;
    for (int i = 0; i < 5; i++) step("count", 0, 1, 1, 0, 8'h00, 1, 0, 0);
    chk("count5_q", {24'd0, Q}, 5);
    chk("count5_qb", {24'd0, QB}, 32'hFA);

    // Wrap and TC
    step("wrap_ld", 0, 1, 1, 1, 8'hFE, 0, 0, 0);
    step("wrap_c1", 0, 1, 1, 0, 8'h00, 1, 0, 0);
    chk("wrap_co_at_ff", {31'd0, CO}, 1);
    step("wrap_c2", 0, 1, 1, 0, 8'h00, 1, 0, 0);
    chk("wrap_q0", {24'd0, Q}, 0);
    chk("wrap_tc", {31'd0, TC}, 1);
    step("tcack", 0, 0, 1, 0, 8'h00, 0, 0, 1);
    chk("tcack_tc", {31'd0, TC}, 0);

    // Saturate
    step("sat_ld", 0, 1, 1, 1, 8'hFD, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("sat_cnt", 0, 1, 1, 0, 8'h00, 1, 0, 0);
    chk("sat_q", {24'd0, Q}, 32'hFF);
    chk("sat_tc", {31'd0, TC}, 1);
    chk("sat_co", {31'd0, CO}, 0);

    // Priority: clear over load/count, then load over count
    step("pri_ld40", 0, 1, 1, 1, 8'h40, 0, 0, 0);
    step("pri_clr", 0, 1, 0, 1, 8'h77, 1, 0, 0);
    chk("pri_clr_q", {24'd0, Q}, 0);
    chk("pri_clr_tc", {31'd0, TC}, 0);
    step("pri_ld33", 0, 1, 1, 1, 8'h33, 1, 0, 0);
    chk("pri_ld_q", {24'd0, Q}, 32'h33);

    // Load all ones in wrap mode does not set TC; collision with TCACK
    step("col_ld", 0, 1, 1, 1, 8'hFF, 0, 0, 0);
    chk("ldff_no_tc", {31'd0, TC}, 0);
    step("col", 0, 1, 1, 0, 8'h00, 1, 0, 1);
    chk("col_q", {24'd0, Q}, 0);
    chk("col_tc", {31'd0, TC}, 1);

    // CLK low ignores clear/load/count
    step("clk_low", 0, 0, 0, 1, 8'h55, 1, 1, 0);
    chk("clk_low_q", {24'd0, Q}, 0);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d_r;
      d_r = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 9) == 0),
           d_r,
           ($urandom_range(0, 9) < 7),
           1'($urandom),
           ($urandom_range(0, 9) == 0));
    end

    // Cascade of two 4-bit stages
    cstep(1, 0, 0, 8'h00, 0);
    chk("casc_reset", {24'd0, hi_q, lo_q}, 0);
    cstep(0, 1, 1, 8'h0F, 0);
    chk("casc_ld", {24'd0, hi_q, lo_q}, 32'h0F);
    c_ci = 1'b1; #1;
    chk("casc_co", {31'd0, lo_co}, 1);
    cstep(0, 1, 0, 8'h00, 1);
    chk("casc_cnt", {24'd0, hi_q, lo_q}, 32'h10);
    for (int i = 0; i < 3; i++) cstep(0, 0, 0, 8'h00, 1);
    chk("casc_hold", {24'd0, hi_q, lo_q}, 32'h10);
    cstep(0, 1, 0, 8'h00, 1);
    chk("casc_cnt2", {24'd0, hi_q, lo_q}, 32'h11);
    cstep(1, 1, 1, 8'hAA, 1);
    chk("casc_rst_mid", {24'd0, hi_q, lo_q}, 0);
    chk("casc_qb", {24'd0, hi_qb, lo_qb}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
